// File: rtl/xm_branch_resolve.sv
// xm_branch_resolve: execute-to-memory stage register. Resolves bne/blt,
// emits a one-cycle PC redirect, discards wrong-path instructions after a
// taken branch and turns add/addi/sub overflow into an rstatus write.
module xm_branch_resolve #(
    parameter int unsigned SQUASH_CYCLES = 2,
    parameter int unsigned RSTATUS_REG   = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        in_valid,
    input  logic [2:0]  in_kind,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_result,
    input  logic [31:0] in_target,
    input  logic        isNotEqual,
    input  logic        isLessThan,
    input  logic        overflow,
    output logic        out_valid,
    output logic        out_we,
    output logic [4:0]  out_rd,
    output logic [31:0] out_result,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        squash_active
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] KIND_BNE  = 3'b001;
    localparam logic [2:0] KIND_BLT  = 3'b010;
    localparam logic [2:0] KIND_ADD  = 3'b011;
    localparam logic [2:0] KIND_ADDI = 3'b100;
    localparam logic [2:0] KIND_SUB  = 3'b101;

    typedef enum logic {
        ST_RUN,
        ST_SQUASH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;

    logic              is_branch;
    logic              taken;
    logic              ovf_write;
    logic [DATA_W-1:0] ovf_code;

    // Decode the incoming instruction class and its flags.
    always_comb begin
        is_branch = (in_kind == KIND_BNE) || (in_kind == KIND_BLT);
        taken     = ((in_kind == KIND_BNE) && isNotEqual) ||
                    ((in_kind == KIND_BLT) && isLessThan);
        ovf_write = overflow && ((in_kind == KIND_ADD) ||
                                 (in_kind == KIND_ADDI) ||
                                 (in_kind == KIND_SUB));
        case (in_kind)
            KIND_ADD:  ovf_code = DATA_W'(1);
            KIND_ADDI: ovf_code = DATA_W'(2);
            KIND_SUB:  ovf_code = DATA_W'(3);
            default:   ovf_code = '0;
        endcase
    end

    // Stage register and RUN/SQUASH sequencing; redirect is a single pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= ST_RUN;
            count         <= '0;
            out_valid     <= 1'b0;
            out_we        <= 1'b0;
            out_rd        <= '0;
            out_result    <= '0;
            redirect      <= 1'b0;
            redirect_pc   <= '0;
            squash_active <= 1'b0;
        end else if (stall) begin
            redirect <= 1'b0;
        end else begin
            redirect  <= 1'b0;
            out_valid <= 1'b0;
            out_we    <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (in_valid) begin
                        out_valid <= 1'b1;
                        if (is_branch) begin
                            out_rd     <= in_rd;
                            out_result <= in_result;
                            if (taken) begin
                                redirect      <= 1'b1;
                                redirect_pc   <= in_target;
                                state         <= ST_SQUASH;
                                count         <= CNT_W'(SQUASH_CYCLES);
                                squash_active <= 1'b1;
                            end
                        end else if (ovf_write) begin
                            out_rd     <= RD_W'(RSTATUS_REG);
                            out_result <= ovf_code;
                            out_we     <= 1'b1;
                        end else begin
                            out_rd     <= in_rd;
                            out_result <= in_result;
                            out_we     <= (in_rd != '0);
                        end
                    end
                end
                ST_SQUASH: begin
                    if (count <= CNT_W'(1)) begin
                        count         <= '0;
                        state         <= ST_RUN;
                        squash_active <= 1'b0;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xm_branch_resolve.sv
// Bench for xm_branch_resolve: fixed vector table, directed multi-cycle
// sequences and a randomized run against a behavioural model.
module tb_xm_branch_resolve;

    localparam int SQ = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        in_valid;
    logic [2:0]  in_kind;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic [31:0] in_target;
    logic        isNotEqual;
    logic        isLessThan;
    logic        overflow;
    logic        out_valid;
    logic        out_we;
    logic [4:0]  out_rd;
    logic [31:0] out_result;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        squash_active;

    int total  = 0;
    int passed = 0;

    xm_branch_resolve #(.SQUASH_CYCLES(SQ), .RSTATUS_REG(30)) dut (
        .clock(clock), .reset(reset), .stall(stall), .in_valid(in_valid),
        .in_kind(in_kind), .in_rd(in_rd), .in_result(in_result),
        .in_target(in_target), .isNotEqual(isNotEqual), .isLessThan(isLessThan),
        .overflow(overflow), .out_valid(out_valid), .out_we(out_we),
        .out_rd(out_rd), .out_result(out_result), .redirect(redirect),
        .redirect_pc(redirect_pc), .squash_active(squash_active)
    );

    always #5 clock = ~clock;

    // Behavioural model: remaining wrong-path slots plus expected outputs.
    logic        m_valid, m_we, m_redirect, m_squash;
    logic [4:0]  m_rd;
    logic [31:0] m_result, m_pc;
    int          m_skip;

    task automatic model_edge();
        int k;
        k = int'(in_kind);
        if (!reset) begin
            m_valid = 0; m_we = 0; m_redirect = 0; m_rd = 0;
            m_result = 0; m_pc = 0; m_skip = 0;
        end else if (stall) begin
            m_redirect = 0;
        end else begin
            m_redirect = 0; m_valid = 0; m_we = 0;
            if (m_skip > 0) begin
                m_skip = m_skip - 1;
            end else if (in_valid) begin
                m_valid = 1;
                if (k == 1 || k == 2) begin
                    if ((k == 1 && isNotEqual) || (k == 2 && isLessThan)) begin
                        m_redirect = 1;
                        m_pc       = in_target;
                        m_skip     = SQ;
                    end
                end else if (k >= 3 && k <= 5 && overflow) begin
                    m_we = 1; m_rd = 5'd30; m_result = 32'(k - 2);
                end else begin
                    m_rd = in_rd; m_result = in_result; m_we = (in_rd != 0);
                end
            end
        end
        m_squash = (m_skip > 0);
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".valid"},    32'(out_valid),     32'(m_valid));
        chk({tag, ".we"},       32'(out_we),        32'(m_we));
        chk({tag, ".redirect"}, 32'(redirect),      32'(m_redirect));
        chk({tag, ".squash"},   32'(squash_active), 32'(m_squash));
        chk({tag, ".pc"},       redirect_pc,        m_pc);
        if (m_we) begin
            chk({tag, ".rd"},     32'(out_rd), 32'(m_rd));
            chk({tag, ".result"}, out_result,  m_result);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] k, input logic [4:0] rd,
                         input logic [31:0] res, input logic [31:0] tgt,
                         input logic ne, input logic lt, input logic ov);
        in_valid = v; in_kind = k; in_rd = rd; in_result = res; in_target = tgt;
        isNotEqual = ne; isLessThan = lt; overflow = ov;
    endtask

    typedef struct {
        logic        v;
        logic [2:0]  kind;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        ne, lt, ovf;
        logic        e_valid, e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_res;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1'b1, 3'd0, 5'd3,  32'h11,       1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3,  32'h11};
        vecs[1]  = '{1'b1, 3'd1, 5'd4,  32'h22,       1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[2]  = '{1'b1, 3'd2, 5'd4,  32'h22,       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[3]  = '{1'b1, 3'd3, 5'd8,  32'h99,       1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd30, 32'd1};
        vecs[4]  = '{1'b1, 3'd4, 5'd9,  32'h99,       1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd30, 32'd2};
        vecs[5]  = '{1'b1, 3'd5, 5'd10, 32'h99,       1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd30, 32'd3};
        vecs[6]  = '{1'b1, 3'd3, 5'd11, 32'h55,       1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd11, 32'h55};
        vecs[7]  = '{1'b1, 3'd0, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[8]  = '{1'b1, 3'd3, 5'd0,  32'h1234,     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd30, 32'd1};
        vecs[9]  = '{1'b1, 3'd6, 5'd12, 32'h77,       1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 32'h77};
        vecs[10] = '{1'b1, 3'd0, 5'd13, 32'h88,       1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd13, 32'h88};
        vecs[11] = '{1'b0, 3'd0, 5'd15, 32'h66,       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[12] = '{1'b1, 3'd5, 5'd0,  32'h5,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[13] = '{1'b1, 3'd7, 5'd14, 32'hCAFE,     1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd14, 32'hCAFE};

        // Reset held with a taken bne on the inputs
        reset = 1'b0; stall = 1'b0;
        drive(1'b1, 3'd1, 5'd3, 32'h5, 32'h40, 1'b1, 1'b0, 1'b0);
        step(); step();
        chk("rst.valid",    32'(out_valid),     32'd0);
        chk("rst.we",       32'(out_we),        32'd0);
        chk("rst.redirect", 32'(redirect),      32'd0);
        chk("rst.squash",   32'(squash_active), 32'd0);
        chk("rst.rd",       32'(out_rd),        32'd0);
        chk("rst.result",   out_result,         32'd0);
        chk("rst.pc",       redirect_pc,        32'd0);
        reset = 1'b1;
        drive(1'b1, 3'd0, 5'd2, 32'hBEEF, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        chk("post_rst.valid",  32'(out_valid), 32'd1);
        chk("post_rst.rd",     32'(out_rd),    32'd2);
        chk("post_rst.result", out_result,     32'hBEEF);

        // Single-cycle vector table
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, vecs[i].kind, vecs[i].rd, vecs[i].res, 32'h0,
                  vecs[i].ne, vecs[i].lt, vecs[i].ovf);
            step();
            chk($sformatf("vec%0d.valid", i),    32'(out_valid),     32'(vecs[i].e_valid));
            chk($sformatf("vec%0d.we", i),       32'(out_we),        32'(vecs[i].e_we));
            chk($sformatf("vec%0d.redirect", i), 32'(redirect),      32'd0);
            chk($sformatf("vec%0d.squash", i),   32'(squash_active), 32'd0);
            if (vecs[i].e_we) begin
                chk($sformatf("vec%0d.rd", i),     32'(out_rd), 32'(vecs[i].e_rd));
                chk($sformatf("vec%0d.result", i), out_result,  vecs[i].e_res);
            end
        end

        // Taken bne, two discarded slots, then a normal ALU op
        drive(1'b1, 3'd1, 5'd1, 32'h0, 32'h40, 1'b1, 1'b0, 1'b0);
        step();
        chk("bne.redirect", 32'(redirect),      32'd1);
        chk("bne.pc",       redirect_pc,        32'h40);
        chk("bne.we",       32'(out_we),        32'd0);
        chk("bne.squash",   32'(squash_active), 32'd1);
        drive(1'b1, 3'd0, 5'd5, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        chk("bne.d1.valid",    32'(out_valid),     32'd0);
        chk("bne.d1.redirect", 32'(redirect),      32'd0);
        chk("bne.d1.squash",   32'(squash_active), 32'd1);
        step();
        chk("bne.d2.valid",  32'(out_valid),     32'd0);
        chk("bne.d2.squash", 32'(squash_active), 32'd0);
        step();
        chk("bne.acc.we",     32'(out_we),  32'd1);
        chk("bne.acc.rd",     32'(out_rd),  32'd5);
        chk("bne.acc.result", out_result,   32'h1234);

        // Not-taken blt, then overflowing sub and addi
        drive(1'b1, 3'd2, 5'd6, 32'h0, 32'h80, 1'b1, 1'b0, 1'b0);
        step();
        chk("blt.valid",    32'(out_valid), 32'd1);
        chk("blt.we",       32'(out_we),    32'd0);
        chk("blt.redirect", 32'(redirect),  32'd0);
        drive(1'b1, 3'd5, 5'd7, 32'h7777, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        chk("sub_ovf.rd",     32'(out_rd), 32'd30);
        chk("sub_ovf.result", out_result,  32'd3);
        chk("sub_ovf.we",     32'(out_we), 32'd1);
        drive(1'b1, 3'd4, 5'd7, 32'h7777, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        chk("addi_ovf.result", out_result, 32'd2);

        // Stall in the middle of a squash
        drive(1'b1, 3'd2, 5'd1, 32'h0, 32'h80, 1'b0, 1'b1, 1'b0);
        step();
        chk("st.redirect", 32'(redirect), 32'd1);
        chk("st.pc",       redirect_pc,   32'h80);
        drive(1'b1, 3'd0, 5'd9, 32'h9999, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        chk("st.d1.valid",    32'(out_valid), 32'd0);
        chk("st.d1.redirect", 32'(redirect),  32'd0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("st.hold%0d.redirect", i), 32'(redirect),      32'd0);
            chk($sformatf("st.hold%0d.squash", i),   32'(squash_active), 32'd1);
            chk($sformatf("st.hold%0d.valid", i),    32'(out_valid),     32'd0);
        end
        stall = 1'b0;
        step();
        chk("st.d2.valid",  32'(out_valid),     32'd0);
        chk("st.d2.squash", 32'(squash_active), 32'd0);
        step();
        chk("st.acc.valid", 32'(out_valid), 32'd1);
        chk("st.acc.rd",    32'(out_rd),    32'd9);

        // Reset while one squash slot remains
        drive(1'b1, 3'd1, 5'd1, 32'h0, 32'hC0, 1'b1, 1'b0, 1'b0);
        step();
        step();
        chk("rs.mid.squash", 32'(squash_active), 32'd1);
        reset = 1'b0;
        step();
        chk("rs.squash", 32'(squash_active), 32'd0);
        chk("rs.valid",  32'(out_valid),     32'd0);
        chk("rs.pc",     redirect_pc,        32'd0);
        reset = 1'b1;
        drive(1'b1, 3'd0, 5'd9, 32'hABCD, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        chk("rs.acc.valid",  32'(out_valid), 32'd1);
        chk("rs.acc.we",     32'(out_we),    32'd1);
        chk("rs.acc.rd",     32'(out_rd),    32'd9);
        chk("rs.acc.result", out_result,     32'hABCD);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 39) != 0);
            stall = ($urandom_range(0, 4) == 0);
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                  $urandom, $urandom,
                  1'($urandom), 1'($urandom), 1'($urandom));
            step();
            chk_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
